// File: rtl/tmds_serializer_if.sv
// Symbol input handshake for the TMDS serializer.
// The master drives symbols and valid. The slave returns ready.
interface tmds_serializer_if #(
  parameter int CHANNELS = 3
);
  logic [CHANNELS*10-1:0] in_symbols;
  logic                   in_valid;
  logic                   in_ready;

  modport master (
    output in_symbols,
    output in_valid,
    input  in_ready
  );

  modport slave (
    input  in_symbols,
    input  in_valid,
    output in_ready
  );
endinterface

// File: rtl/tmds_serializer.sv
// TMDS serializer: symbol FIFO feeding per-channel shift registers.
// Includes the clock-channel pattern and idle-symbol underflow fill.
module tmds_serializer #(
  parameter int          CHANNELS     = 3,
  parameter int          BITS_PER_CLK = 1,
  parameter int          FIFO_DEPTH   = 4,
  parameter bit          MSB_FIRST    = 1'b0,
  parameter logic [9:0]  IDLE_SYMBOL  = 10'b1101010100
) (
  input  logic                             clk,
  input  logic                             reset,
  tmds_serializer_if.slave                 in_if,
  input  logic                             clear_underflow,
  output logic [CHANNELS*BITS_PER_CLK-1:0] out_data,
  output logic [BITS_PER_CLK-1:0]          out_clk,
  output logic                             symbol_start,
  output logic [$clog2(FIFO_DEPTH+1)-1:0]  fifo_level,
  output logic                             underflow
);
  localparam int B     = BITS_PER_CLK;
  localparam int SLOTS = 10 / B;
  localparam int PW    = (SLOTS > 1) ? $clog2(SLOTS) : 1;
  localparam int AW    = $clog2(FIFO_DEPTH);
  localparam int LW    = $clog2(FIFO_DEPTH+1);
  localparam logic [PW-1:0] LAST    = PW'(SLOTS-1);
  localparam logic [9:0]    CLK_PAT = 10'b0000011111;

  if (!(B == 1 || B == 2 || B == 5 || B == 10)) begin : g_bad_bpc
    $error("BITS_PER_CLK must be 1, 2, 5 or 10");
  end
  if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH-1)) != 0) begin : g_bad_depth
    $error("FIFO_DEPTH must be a power of two >= 2");
  end

  logic [PW-1:0]           phase_q, phase_d;
  logic [AW-1:0]           wptr_q, wptr_d;
  logic [AW-1:0]           rptr_q, rptr_d;
  logic [LW-1:0]           level_q, level_d;
  logic                    armed_q, armed_d;
  logic                    uflow_q, uflow_d;
  logic                    start_q, start_d;
  logic [9:0]              data_q [CHANNELS];
  logic [9:0]              data_d [CHANNELS];
  logic [9:0]              clk_q, clk_d;
  logic [CHANNELS*10-1:0]  mem_q [FIFO_DEPTH];
  logic [CHANNELS*10-1:0]  head;
  logic                    load, empty, push, pop, rdy;

  assign rdy            = level_q < LW'(FIFO_DEPTH);
  assign in_if.in_ready = rdy;
  assign head           = mem_q[rptr_q];

  always_comb begin
    load    = (phase_q == LAST);
    empty   = (level_q == '0);
    push    = in_if.in_valid && rdy;
    pop     = load && !empty;
    phase_d = load ? '0 : phase_q + PW'(1);
    wptr_d  = push ? wptr_q + AW'(1) : wptr_q;
    rptr_d  = pop ? rptr_q + AW'(1) : rptr_q;
    level_d = level_q;
    case ({push, pop})
      2'b10:   level_d = level_q + LW'(1);
      2'b01:   level_d = level_q - LW'(1);
      default: level_d = level_q;
    endcase
    data_d  = data_q;
    clk_d   = MSB_FIRST ? (clk_q << B) : (clk_q >> B);
    for (int c = 0; c < CHANNELS; c++) begin
      if (load)
        data_d[c] = empty ? IDLE_SYMBOL : head[c*10 +: 10];
      else
        data_d[c] = MSB_FIRST ? (data_q[c] << B) : (data_q[c] >> B);
    end
    if (load) clk_d = CLK_PAT;
    armed_d = armed_q | push;
    // Setting takes priority over a coincident clear.
    if (load && armed_q && empty) uflow_d = 1'b1;
    else if (clear_underflow)     uflow_d = 1'b0;
    else                          uflow_d = uflow_q;
    start_d = (phase_d == '0);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      phase_q <= '0;
      wptr_q  <= '0;
      rptr_q  <= '0;
      level_q <= '0;
      armed_q <= 1'b0;
      uflow_q <= 1'b0;
      start_q <= 1'b1;
      clk_q   <= CLK_PAT;
      for (int c = 0; c < CHANNELS; c++) data_q[c] <= IDLE_SYMBOL;
    end else begin
      phase_q <= phase_d;
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      level_q <= level_d;
      armed_q <= armed_d;
      uflow_q <= uflow_d;
      start_q <= start_d;
      clk_q   <= clk_d;
      data_q  <= data_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem_q[wptr_q] <= in_if.in_symbols;
  end

  for (genvar c = 0; c < CHANNELS; c++) begin : g_out
    if (MSB_FIRST) begin : g_msb
      assign out_data[c*B +: B] = data_q[c][9 -: B];
    end else begin : g_lsb
      assign out_data[c*B +: B] = data_q[c][B-1:0];
    end
  end

  if (MSB_FIRST) begin : g_clk_msb
    assign out_clk = clk_q[9 -: B];
  end else begin : g_clk_lsb
    assign out_clk = clk_q[B-1:0];
  end

  assign symbol_start = start_q;
  assign fifo_level   = level_q;
  assign underflow    = uflow_q;
endmodule
